dfe_out_buffer: RTL and testbench
=================================

Name: dfe_out_buffer

Overview:
- Output stage directly downstream of the DFE top-level filter chain.
- Consumes the chain's final sample stream and its overflow/underflow flags. The chain produces a one-cycle valid pulse per sample and has no backpressure.
- Buffers samples in a synchronous FIFO and presents them on a valid/ready stream to the downstream sink (DMA/serializer).
- Keeps sticky status and a drop counter for software readout over APB.

Parameters:
- DATA_WIDTH, 16, sample width (signed, Q1.15).
- DEPTH, 16, FIFO entries; must be a power of two, minimum 2.
- DROP_WIDTH, 16, width of the saturating drop counter.
- CNT_WIDTH (localparam), $clog2(DEPTH)+1, occupancy width.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- valid_in  in  1  sample strobe from the filter chain (core valid_out).
- data_in  in  DATA_WIDTH  signed sample from the filter chain (core_out).
- ovf_in  in  1  chain overflow flag.
- unf_in  in  1  chain underflow flag.
- clr_status  in  1  one-cycle pulse; clears stickies and drop counter.
- m_valid  out  1  output sample available.
- m_data  out  DATA_WIDTH  output sample (head of FIFO).
- m_ready  in  1  sink accepts m_data this cycle.
- level  out  CNT_WIDTH  current FIFO occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- sticky_ovf  out  1  latched ovf_in.
- sticky_unf  out  1  latched unf_in.
- sticky_drop  out  1  at least one sample was dropped.
- drop_cnt  out  DROP_WIDTH  number of dropped samples, saturating.

Behaviour:
- Reset (rst_n low at a clock edge): pointers=0, level=0, empty=1, full=0, m_valid=0, m_data=0, all stickies=0, drop_cnt=0. FIFO memory contents are not reset.
- Reset mid-operation discards all buffered data; the first edge after release behaves as from empty.
- pop = m_valid && m_ready.
- push = valid_in && (!full || pop).
- drop = valid_in && full && !pop.
- First-word fall-through:
  - m_valid = !empty; m_data = mem[rd_ptr]. m_data is driven 0 when empty.
  - Write-to-read latency: a sample pushed at edge k is visible on m_data after edge k (m_valid high in cycle k+1) if the FIFO was empty.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The level counter updates +1 on push only, -1 on pop only, unchanged on both or neither.
- Simultaneous push and pop when full: both occur, level stays DEPTH, no drop.
- Simultaneous push and pop when empty: impossible, since m_valid=0 means no pop. Push proceeds normally.
- m_ready high while empty: no effect and no underflow of level.
- Valid/ready rule: m_data and m_valid hold stable while m_valid=1 and m_ready=0.
- drop behaviour: the sample is discarded, sticky_drop is set, and drop_cnt increments, saturating at 2^DROP_WIDTH-1 (no wrap).
- sticky_ovf / sticky_unf set on any cycle where ovf_in / unf_in = 1, independent of valid_in.
- clr_status clears all three stickies and drop_cnt at the next edge.
- clr_status coincident with a set or drop event: the event wins. The sticky ends at 1 and drop_cnt ends at 1, not 0 or old+1.
- Data is passed bit-exact: no arithmetic and no width change.

Decomposition:
- Shared package dfe_pkg holds:
  - DATA_WIDTH_DEF = 16
  - DROP_WIDTH_DEF = 16
  - typedef sample_t (logic signed [15:0])
  - typedef dfe_status_t, a packed struct {ovf, unf, drop}, reused by the APB status register map.
- One sub-module: dfe_sync_fifo. It is the generic FWFT FIFO (memory, pointers, level, full/empty, push/pop).
- dfe_out_buffer wraps dfe_sync_fifo and adds the drop/sticky/counter logic.

Test Plan:
- Reset then idle: all outputs 0 except empty=1; level=0 held for 10 cycles.
- Push 5 samples 0x0001..0x0005 with m_ready=0: level=5, m_valid=1, m_data=0x0001 held. Then m_ready=1 for 5 cycles: outputs 0x0001..0x0005 in order, then empty=1.
- Push 20 samples with DEPTH=16 and m_ready=0: full=1 after the 16th. Samples 17-20 dropped: drop_cnt=4, sticky_drop=1. Reading drains exactly samples 1-16.
- Full FIFO with valid_in=1 and m_ready=1 every cycle for 40 cycles: level stays 16, drop_cnt=0. Output order is preserved across pointer wrap (≥2 wraps).
- Pulse ovf_in for 1 cycle: sticky_ovf=1. Pulse clr_status alone: sticky_ovf=0, drop_cnt=0. unf_in and clr_status in the same cycle: sticky_unf=1.
- Force 2^16+3 drops (or use DROP_WIDTH=4 with 20 drops): drop_cnt saturates at all-ones. Assert rst_n=0 mid-stream: next cycle level=0, empty=1, drop_cnt=0.

Source files
------------

// File: rtl/dfe_pkg.sv
// dfe_pkg: shared DFE defaults, sample type and status record
package dfe_pkg;
  localparam int DATA_WIDTH_DEF = 16;
  localparam int DROP_WIDTH_DEF = 16;
  typedef logic signed [15:0] sample_t;
  typedef struct packed {
    logic ovf;
    logic unf;
    logic drop;
  } dfe_status_t;
endpackage

// File: rtl/dfe_sync_fifo.sv
// dfe_sync_fifo: generic first-word-fall-through synchronous FIFO
module dfe_sync_fifo #(
  parameter int DW = 16,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic [CW-1:0] level,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] level_q, level_d;
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d  = level_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= wdata;
  assign level = level_q;
  assign empty = level_q == '0;
  assign full  = level_q == CW'(DEPTH);
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/dfe_out_buffer.sv
// dfe_out_buffer: buffers DFE chain output, tracks drops and sticky status
module dfe_out_buffer
  import dfe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH = 16,
  parameter int DROP_WIDTH = DROP_WIDTH_DEF,
  localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ovf_in,
  input  logic                  unf_in,
  input  logic                  clr_status,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  level,
  output logic                  full,
  output logic                  empty,
  output logic                  sticky_ovf,
  output logic                  sticky_unf,
  output logic                  sticky_drop,
  output logic [DROP_WIDTH-1:0] drop_cnt
);
  logic pop, push, drop;
  dfe_status_t status_q, status_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  assign m_valid = !empty;
  assign pop  = m_valid && m_ready;
  assign push = valid_in && (!full || pop);
  assign drop = valid_in && full && !pop;
  dfe_sync_fifo #(.DW(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (data_in),
    .pop   (pop),
    .rdata (m_data),
    .level (level),
    .full  (full),
    .empty (empty)
  );
  // a set/drop event in the same cycle as clr_status takes priority over the clear
  always_comb begin
    status_d.ovf  = ovf_in || (status_q.ovf && !clr_status);
    status_d.unf  = unf_in || (status_q.unf && !clr_status);
    status_d.drop = drop || (status_q.drop && !clr_status);
    drop_cnt_d = !drop ? (clr_status ? '0 : drop_cnt_q)
               : clr_status ? DROP_WIDTH'(1)
               : &drop_cnt_q ? drop_cnt_q : drop_cnt_q + DROP_WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      status_q   <= status_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
  assign sticky_ovf  = status_q.ovf;
  assign sticky_unf  = status_q.unf;
  assign sticky_drop = status_q.drop;
  assign drop_cnt    = drop_cnt_q;
endmodule

// File: tb/tb_dfe_out_buffer.sv
// tb_dfe_out_buffer: directed checks of dfe_out_buffer (DEPTH=16, DROP_WIDTH=4)
module tb_dfe_out_buffer;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        valid_in = 0;
  logic [15:0] data_in = 0;
  logic        ovf_in = 0, unf_in = 0, clr_status = 0, m_ready = 0;
  logic        m_valid, full, empty, sticky_ovf, sticky_unf, sticky_drop;
  logic [15:0] m_data;
  logic [4:0]  level;
  logic [3:0]  drop_cnt;
  int total = 0, bad = 0;
  logic [15:0] exp_out, nxt_in;
  always #5 clk = ~clk;
  dfe_out_buffer #(.DATA_WIDTH(16), .DEPTH(16), .DROP_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .data_in(data_in),
    .ovf_in(ovf_in), .unf_in(unf_in), .clr_status(clr_status),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .level(level), .full(full), .empty(empty),
    .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .sticky_drop(sticky_drop),
    .drop_cnt(drop_cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  initial begin
    tick();
    tick();
    rst_n = 1;
    chk("rst_level", 32'(level), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_mvalid", 32'(m_valid), 0);
    chk("rst_mdata", 32'(m_data), 0);
    chk("rst_sticky", {29'd0, sticky_ovf, sticky_unf, sticky_drop}, 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_level", 32'(level), 0);
    end
    valid_in = 1;
    for (int i = 1; i <= 5; i++) begin
      data_in = 16'(i);
      tick();
      if (i == 1) chk("fwft_first", 32'(m_data), 1);
    end
    valid_in = 0;
    chk("five_level", 32'(level), 5);
    chk("five_mvalid", 32'(m_valid), 1);
    tick();
    tick();
    chk("hold_mdata", 32'(m_data), 1);
    chk("hold_level", 32'(level), 5);
    m_ready = 1;
    for (int i = 1; i <= 5; i++) begin
      chk("drain5_data", 32'(m_data), 32'(i));
      tick();
    end
    chk("drain5_empty", 32'(empty), 1);
    chk("drain5_mvalid", 32'(m_valid), 0);
    tick();
    chk("ready_empty_level", 32'(level), 0);
    m_ready = 0;
    valid_in = 1;
    for (int i = 1; i <= 20; i++) begin
      data_in = 16'h0100 + 16'(i);
      tick();
      if (i == 15) chk("full_at15", 32'(full), 0);
      if (i == 16) chk("full_at16", 32'(full), 1);
    end
    valid_in = 0;
    chk("ovr_level", 32'(level), 16);
    chk("ovr_drop", 32'(drop_cnt), 4);
    chk("ovr_sticky", 32'(sticky_drop), 1);
    m_ready = 1;
    for (int i = 1; i <= 16; i++) begin
      chk("drain16_data", 32'(m_data), 32'h0100 + 32'(i));
      tick();
    end
    chk("drain16_empty", 32'(empty), 1);
    m_ready = 0;
    clr_status = 1;
    tick();
    clr_status = 0;
    chk("clr_drop", 32'(drop_cnt), 0);
    chk("clr_sticky", 32'(sticky_drop), 0);
    valid_in = 1;
    for (int i = 1; i <= 16; i++) begin
      data_in = 16'h0200 + 16'(i);
      tick();
    end
    exp_out = 16'h0201;
    nxt_in = 16'h0211;
    m_ready = 1;
    for (int i = 0; i < 40; i++) begin
      data_in = nxt_in;
      chk("stream_data", 32'(m_data), 32'(exp_out));
      tick();
      chk("stream_level", 32'(level), 16);
      exp_out++;
      nxt_in++;
    end
    chk("stream_drop", 32'(drop_cnt), 0);
    valid_in = 0;
    for (int i = 0; i < 16; i++) begin
      chk("wrap_drain", 32'(m_data), 32'(exp_out));
      tick();
      exp_out++;
    end
    chk("wrap_empty", 32'(empty), 1);
    m_ready = 0;
    ovf_in = 1;
    tick();
    ovf_in = 0;
    chk("ovf_set", 32'(sticky_ovf), 1);
    chk("ovf_unf_clear", 32'(sticky_unf), 0);
    tick();
    chk("ovf_hold", 32'(sticky_ovf), 1);
    clr_status = 1;
    tick();
    chk("clr_ovf", 32'(sticky_ovf), 0);
    chk("clr_dropcnt", 32'(drop_cnt), 0);
    unf_in = 1;
    tick();
    unf_in = 0;
    clr_status = 0;
    chk("unf_vs_clr", 32'(sticky_unf), 1);
    valid_in = 1;
    for (int i = 0; i < 36; i++) begin
      data_in = 16'(i);
      tick();
    end
    chk("sat_drop", 32'(drop_cnt), 15);
    clr_status = 1;
    tick();
    clr_status = 0;
    chk("drop_vs_clr_cnt", 32'(drop_cnt), 1);
    chk("drop_vs_clr_sticky", 32'(sticky_drop), 1);
    rst_n = 0;
    tick();
    chk("midrst_level", 32'(level), 0);
    chk("midrst_empty", 32'(empty), 1);
    chk("midrst_drop", 32'(drop_cnt), 0);
    chk("midrst_mvalid", 32'(m_valid), 0);
    rst_n = 1;
    data_in = 16'h0ABC;
    tick();
    valid_in = 0;
    chk("post_rst_data", 32'(m_data), 32'h0ABC);
    chk("post_rst_level", 32'(level), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
